// File: rtl/uart_bus_slave.sv
// UART peripheral as seen from the IO bus: a 4-register window with a TX FIFO, an 8N1
// serializer and an RX holding register. All parity is even over the 32 data bits.
module uart_bus_slave #(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter logic [15:0] CLK_DIV       = 16'd434,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] bus_addr,
    input  logic        bus_rw,
    input  logic        bus_write_ready,
    input  logic [32:0] bus_write_data,
    output logic        bus_read_ready,
    output logic [32:0] bus_read_data,
    output logic        bus_error,
    output logic        write_finish,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        uart_txd
);

    localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StWrData, StResp} bus_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    bus_state_e  bus_state_q, bus_state_d;
    logic [1:0]  sel_q, sel_d;
    logic        addr_ok_q, addr_ok_d;
    logic        rd_ready_q, rd_ready_d;
    logic [32:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic        fin_q, fin_d;

    logic [7:0]  mem_q [TX_FIFO_DEPTH];
    logic [7:0]  mem_d [TX_FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;

    logic [15:0] div_q, div_d;
    logic [7:0]  rx_hold_q, rx_hold_d;
    logic        rx_full_q, rx_full_d;
    logic        overrun_q, overrun_d;

    logic [31:0] off;
    logic        cmd_ok;
    logic [1:0]  cmd_sel;
    logic [31:0] rd_val;
    logic        tx_full, tx_empty, tx_busy;
    logic        push, pop, div_we, rx_clear, bit_end;

    // Offset arithmetic keeps the window check correct for any word-aligned base.
    assign off     = bus_addr - BASE_ADDR;
    assign cmd_ok  = (off[31:4] == 28'd0) && (off[1:0] == 2'b00);
    assign cmd_sel = off[3:2];

    assign tx_empty = (wptr_q == rptr_q);
    assign tx_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign tx_busy  = (tx_state_q != TxIdle);
    assign pop      = (tx_state_q == TxIdle) && !tx_empty;

    always_comb begin
        rd_val = 32'd0;
        case (cmd_sel)
            2'd1:    rd_val = {24'd0, rx_hold_q};
            2'd2:    rd_val = {27'd0, tx_busy, overrun_q, rx_full_q, tx_empty, tx_full};
            2'd3:    rd_val = {16'd0, div_q};
            default: rd_val = 32'd0;
        endcase
    end

    always_comb begin
        bus_state_d = bus_state_q;
        sel_d       = sel_q;
        addr_ok_d   = addr_ok_q;
        rd_ready_d  = 1'b0;
        rd_data_d   = rd_data_q;
        err_d       = 1'b0;
        fin_d       = 1'b0;
        push        = 1'b0;
        div_we      = 1'b0;
        rx_clear    = 1'b0;
        case (bus_state_q)
            StIdle: begin
                if (bus_write_ready) begin
                    sel_d       = cmd_sel;
                    addr_ok_d   = cmd_ok;
                    bus_state_d = StWrData;
                end else if (bus_rw == 1'b0) begin
                    sel_d       = cmd_sel;
                    addr_ok_d   = cmd_ok;
                    bus_state_d = StResp;
                    if (cmd_ok) begin
                        rd_ready_d = 1'b1;
                        rd_data_d  = {^rd_val, rd_val};
                        rx_clear   = (cmd_sel == 2'd1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrData: begin
                bus_state_d = StResp;
                if ((^bus_write_data) || !addr_ok_q) begin
                    err_d = 1'b1;
                end else if (sel_q == 2'd0) begin
                    if (tx_full) begin
                        err_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        fin_d = 1'b1;
                    end
                end else begin
                    div_we = (sel_q == 2'd3);
                    fin_d  = 1'b1;
                end
            end
            StResp:  bus_state_d = StIdle;
            default: bus_state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = bus_write_data[7:0];
            wptr_d                = wptr_q + PtrOne;
        end
        if (pop) begin
            rptr_d = rptr_q + PtrOne;
        end
    end

    always_comb begin
        div_d = div_q;
        if (div_we) begin
            div_d = (bus_write_data[15:0] == 16'd0) ? 16'd1 : bus_write_data[15:0];
        end
    end

    // A byte landing on the same edge as an RXDATA read survives; only the overrun clears.
    always_comb begin
        rx_hold_d = rx_hold_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        if (rx_valid) begin
            rx_hold_d = rx_byte;
            rx_full_d = 1'b1;
            overrun_d = rx_clear ? 1'b0 : (overrun_q | rx_full_q);
        end else if (rx_clear) begin
            rx_full_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign bit_end = (cnt_q == bit_div_q - 16'd1);

    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        bit_div_d  = bit_div_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        case (tx_state_q)
            TxIdle: begin
                if (pop) begin
                    shift_d    = mem_q[rptr_q[AW-1:0]];
                    bit_div_d  = div_q;
                    cnt_d      = 16'd0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d      = 16'd0;
                    bit_idx_d  = 3'd0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            TxStop: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d      = 16'd0;
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_state_q <= StIdle;
            sel_q       <= 2'd0;
            addr_ok_q   <= 1'b0;
            rd_ready_q  <= 1'b0;
            rd_data_q   <= 33'd0;
            err_q       <= 1'b0;
            fin_q       <= 1'b0;
            for (int i = 0; i < TX_FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            tx_state_q  <= TxIdle;
            cnt_q       <= 16'd0;
            bit_div_q   <= CLK_DIV;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            txd_q       <= 1'b1;
            div_q       <= CLK_DIV;
            rx_hold_q   <= 8'd0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bus_state_q <= bus_state_d;
            sel_q       <= sel_d;
            addr_ok_q   <= addr_ok_d;
            rd_ready_q  <= rd_ready_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            fin_q       <= fin_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            tx_state_q  <= tx_state_d;
            cnt_q       <= cnt_d;
            bit_div_q   <= bit_div_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            div_q       <= div_d;
            rx_hold_q   <= rx_hold_d;
            rx_full_q   <= rx_full_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus_read_ready = rd_ready_q;
    assign bus_read_data  = rd_data_q;
    assign bus_error      = err_q;
    assign write_finish   = fin_q;
    assign uart_txd       = txd_q;

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed bench for uart_bus_slave: bus transactions, serial framing, RX status and reset.
module tb_uart_bus_slave;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] bus_addr;
    logic        bus_rw;
    logic        bus_write_ready;
    logic [32:0] bus_write_data;
    logic        bus_read_ready;
    logic [32:0] bus_read_data;
    logic        bus_error;
    logic        write_finish;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;

    uart_bus_slave dut (
        .clk             (clk),
        .resetn          (resetn),
        .bus_addr        (bus_addr),
        .bus_rw          (bus_rw),
        .bus_write_ready (bus_write_ready),
        .bus_write_data  (bus_write_data),
        .bus_read_ready  (bus_read_ready),
        .bus_read_data   (bus_read_data),
        .bus_error       (bus_error),
        .write_finish    (write_finish),
        .rx_valid        (rx_valid),
        .rx_byte         (rx_byte),
        .uart_txd        (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic flip,
                             input logic exp_err, input string tag);
        bus_addr        = a;
        bus_rw          = 1'b1;
        bus_write_ready = 1'b1;
        cyc();
        bus_write_ready = 1'b0;
        bus_addr        = 32'd0;
        bus_write_data  = {(^d) ^ flip, d};
        chk1({tag, "_early_fin"}, write_finish, 1'b0);
        cyc();
        chk1({tag, "_fin"}, write_finish, !exp_err);
        chk1({tag, "_err"}, bus_error, exp_err);
        bus_write_data = 33'd0;
        cyc();
    endtask

    task automatic bus_read(input logic [31:0] a, input logic rx_v, input logic [7:0] rx_b,
                            input logic exp_err, input string tag, output logic [32:0] data);
        bus_addr = a;
        bus_rw   = 1'b0;
        rx_valid = rx_v;
        rx_byte  = rx_b;
        cyc();
        bus_rw   = 1'b1;
        rx_valid = 1'b0;
        chk1({tag, "_rdy"}, bus_read_ready, !exp_err);
        chk1({tag, "_err"}, bus_error, exp_err);
        data = bus_read_data;
        cyc();
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        cyc();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [32:0] rd;
        logic [9:0]  frame;
        int          zeros;
        int          waited;

        resetn          = 1'b0;
        bus_addr        = 32'd0;
        bus_rw          = 1'b1;
        bus_write_ready = 1'b0;
        bus_write_data  = 33'd0;
        rx_valid        = 1'b0;
        rx_byte         = 8'd0;
        cyc(3);
        resetn = 1'b1;
        cyc();
        chk1("rst_txd", uart_txd, 1'b1);
        chk1("rst_rdy", bus_read_ready, 1'b0);
        chk1("rst_err", bus_error, 1'b0);
        chk1("rst_fin", write_finish, 1'b0);
        chk("rst_rdata", bus_read_data, 33'd0);

        // 1: DIV=4, send 0x41; start bit begins the cycle after the response.
        bus_write(BASE + 32'hC, 32'd4, 1'b0, 1'b0, "t1_div");
        bus_write(BASE, 32'h41, 1'b0, 1'b0, "t1_tx");
        frame = {1'b1, 8'h41, 1'b0};
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("t1_bit%0d", i), uart_txd, frame[i]);
            cyc(4);
        end
        cyc(5);

        // 2: bad parity is rejected, nothing is queued.
        bus_write(BASE, 32'h41, 1'b1, 1'b1, "t2_par");
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            if (uart_txd !== 1'b1) zeros++;
            cyc();
        end
        chk1("t2_txd_idle", (zeros == 0), 1'b1);
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "t2_stat", rd);
        chk("t2_stat_val", rd, {1'b1, 32'h2});

        // 3: slow bit rate; a primer byte occupies the shifter, then four fill the FIFO.
        bus_write(BASE + 32'hC, 32'd1000, 1'b0, 1'b0, "t3_div");
        bus_write(BASE, 32'h55, 1'b0, 1'b0, "t3_prime");
        for (int i = 1; i <= 4; i++) begin
            bus_write(BASE, i, 1'b0, 1'b0, $sformatf("t3_w%0d", i));
        end
        bus_write(BASE, 32'h5, 1'b0, 1'b1, "t3_w5");
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "t3_stat", rd);
        chk("t3_stat_val", rd, {1'b0, 32'h11});
        bus_read(BASE, 1'b0, 8'd0, 1'b0, "t3_txrd", rd);
        chk("t3_txrd_val", rd, 33'd0);
        bus_write(BASE + 32'h4, 32'h77, 1'b0, 1'b0, "t3_rxwr");
        bus_write(BASE + 32'h10, 32'h77, 1'b0, 1'b1, "t3_badwr");

        // 4: single received byte.
        rx_pulse(8'hA5);
        bus_read(BASE + 32'h4, 1'b0, 8'd0, 1'b0, "t4_rx", rd);
        chk("t4_rx_val", rd, {1'b0, 32'hA5});
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "t4_stat", rd);
        chk("t4_stat_val", rd, {1'b0, 32'h11});

        // 5: overrun, last byte wins.
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "t5_stat", rd);
        chk("t5_stat_val", rd, {1'b0, 32'h1D});
        bus_read(BASE + 32'h4, 1'b0, 8'd0, 1'b0, "t5_rx", rd);
        chk("t5_rx_val", rd, {1'b0, 32'h22});
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "t5_stat2", rd);
        chk("t5_stat2_val", rd, {1'b0, 32'h11});

        // New byte arriving with the RXDATA read.
        rx_pulse(8'h33);
        bus_read(BASE + 32'h4, 1'b1, 8'h44, 1'b0, "tc_rx", rd);
        chk("tc_rx_val", rd, {1'b0, 32'h33});
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "tc_stat", rd);
        chk("tc_stat_val", rd, {1'b1, 32'h15});
        bus_read(BASE + 32'h4, 1'b0, 8'd0, 1'b0, "tc_rx2", rd);
        chk("tc_rx2_val", rd, {1'b0, 32'h44});

        // DIV=0 is stored as 1.
        bus_write(BASE + 32'hC, 32'd0, 1'b0, 1'b0, "td_div0");
        bus_read(BASE + 32'hC, 1'b0, 8'd0, 1'b0, "td_rd", rd);
        chk("td_rd_val", rd, {1'b1, 32'h1});

        // 6: bad-address reads, then reset in the middle of a frame.
        bus_read(BASE + 32'h10, 1'b0, 8'd0, 1'b1, "t6_bad10", rd);
        bus_read(BASE + 32'h2, 1'b0, 8'd0, 1'b1, "t6_bad2", rd);
        chk("t6_rdata_held", bus_read_data, {1'b1, 32'h1});
        waited = 0;
        while (uart_txd !== 1'b0 && waited < 25000) begin
            cyc();
            waited++;
        end
        chk1("t6_mid_frame", (uart_txd === 1'b0), 1'b1);
        bus_addr = BASE + 32'h8;
        bus_rw   = 1'b0;
        resetn   = 1'b0;
        cyc();
        bus_rw = 1'b1;
        chk1("t6_rst_txd", uart_txd, 1'b1);
        chk1("t6_rst_rdy", bus_read_ready, 1'b0);
        chk1("t6_rst_err", bus_error, 1'b0);
        chk1("t6_rst_fin", write_finish, 1'b0);
        resetn = 1'b1;
        cyc();
        bus_read(BASE + 32'h8, 1'b0, 8'd0, 1'b0, "t6_stat", rd);
        chk("t6_stat_val", rd, {1'b1, 32'h2});
        bus_read(BASE + 32'hC, 1'b0, 8'd0, 1'b0, "t6_div", rd);
        chk("t6_div_val", rd, {1'b1, 32'h1B2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
